// File: rtl/riscv_pkg.sv
// Shared RV32M types for the EX-stage multiply/divide unit: funct3 op encoding,
// FSM states and the divide iteration count.
package riscv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } muldiv_state_e;

    localparam int DIV_ITERS = 32;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Serial unsigned restoring divider: one quotient bit per step, MSB first.
// Its iteration down-counter also paces the shift-add multiplier when that is built.
module div_iter
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo_next,
    output logic [31:0] rem_next,
    output logic        last
);

    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dsr_q;
    logic [5:0]  cnt_q;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        q_bit;

    // The partial remainder never exceeds 2*divisor-1, so 33 bits cover the shift.
    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        diff     = shifted - {1'b0, dsr_q};
        q_bit    = ~diff[32];
        rem_next = q_bit ? diff[31:0] : shifted[31:0];
        quo_next = {quo_q[30:0], q_bit};
    end

    assign last = (cnt_q == 6'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
            cnt_q <= 6'(DIV_ITERS);
        end else if (step) begin
            quo_q <= quo_next;
            rem_q <= rem_next;
            if (cnt_q != 6'd0) begin
                cnt_q <= cnt_q - 6'd1;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
//   state | meaning
//   IDLE  | waiting for start; accept cycle raises busy
//   RUN   | one divide (or shift-add multiply) step per cycle
//   DONE  | result and rd_out presented, done high for one cycle
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter bit MUL_FAST = 1'b1,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    muldiv_state_e state_q, state_d;
    muldiv_op_e    op_in;

    logic        is_div, div_signed, sa_in, sb_in;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf, accept;
    logic [31:0] special_res, div_final, mul_fast_res, mul_slow_res;
    logic [31:0] quo_next, rem_next;
    logic        div_last;

    logic        is_div_q, is_rem_q, neg_q_q, neg_r_q;
    logic [4:0]  rd_q;

    logic        load_res;
    logic [31:0] res_d;
    logic [4:0]  rd_d;

    assign op_in      = muldiv_op_e'(op);
    assign is_div     = op[2];
    assign div_signed = (op_in == OP_DIV) || (op_in == OP_REM);
    assign sa_in      = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && rs1_data[31];
    assign sb_in      = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && rs2_data[31];
    assign a_mag      = cond_neg(rs1_data, sa_in);
    assign b_mag      = cond_neg(rs2_data, sb_in);
    assign div_zero   = (rs2_data == 32'd0);
    assign div_ovf    = div_signed && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    assign accept     = start && (state_q == IDLE) && !kill && !rst;

    // Divide by zero yields all-ones / dividend; overflow yields dividend / zero.
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? rs1_data : 32'hFFFF_FFFF;
        end else begin
            special_res = op[1] ? 32'd0 : rs1_data;
        end
    end

    assign busy = !rst && (((state_q == IDLE) && start && !kill) || (state_q == RUN));
    assign done = (state_q == DONE);

    div_iter u_div_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && (is_div || !MUL_FAST)),
        .step     (state_q == RUN),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo_next (quo_next),
        .rem_next (rem_next),
        .last     (div_last)
    );

    assign div_final = is_rem_q ? cond_neg(rem_next, neg_r_q) : cond_neg(quo_next, neg_q_q);

    generate
        if (MUL_FAST) begin : g_mul_fast
            logic [63:0] prod;
            assign prod         = {{32{sa_in}}, rs1_data} * {{32{sb_in}}, rs2_data};
            assign mul_fast_res = (op_in == OP_MUL) ? prod[31:0] : prod[63:32];
            assign mul_slow_res = '0;
        end else begin : g_mul_slow
            logic [63:0] prod_q, prod_next, prod_fix;
            logic [31:0] mcand_q;
            logic [32:0] sum;
            logic        lo_q;

            // Low half holds the remaining multiplier bits, high half the running sum.
            always_comb begin
                sum       = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
                prod_next = {sum, prod_q[31:1]};
                prod_fix  = neg_q_q ? (64'd0 - prod_next) : prod_next;
            end

            assign mul_slow_res = lo_q ? prod_fix[31:0] : prod_fix[63:32];
            assign mul_fast_res = '0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    prod_q  <= '0;
                    mcand_q <= '0;
                    lo_q    <= 1'b0;
                end else if (accept && !is_div) begin
                    prod_q  <= {32'd0, b_mag};
                    mcand_q <= a_mag;
                    lo_q    <= (op_in == OP_MUL);
                end else if ((state_q == RUN) && !is_div_q) begin
                    prod_q  <= prod_next;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        load_res = 1'b0;
        res_d    = special_res;
        rd_d     = rd_in;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_div) begin
                        state_d  = MUL_FAST ? DONE : RUN;
                        load_res = MUL_FAST;
                        res_d    = mul_fast_res;
                    end else if (div_zero || div_ovf) begin
                        state_d  = DONE;
                        load_res = 1'b1;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (div_last) begin
                    state_d  = DONE;
                    load_res = 1'b1;
                    res_d    = is_div_q ? div_final : mul_slow_res;
                    rd_d     = rd_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result   <= '0;
            rd_out   <= '0;
            rd_q     <= '0;
            is_div_q <= 1'b0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_q     <= rd_in;
                is_div_q <= is_div;
                is_rem_q <= op[1];
                neg_q_q  <= sa_in ^ sb_in;
                neg_r_q  <= sa_in;
            end
            if (load_res) begin
                result <= res_d;
                rd_out <= rd_d;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (MUL_FAST=1): vector table through a
// done-driven scoreboard, plus kill / reset / ignored-start sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    muldiv_unit #(.MUL_FAST(1'b1), .XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .kill     (kill),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: got done=1 at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, result, e.res);
                    chk({e.name, "_rd_out"}, {27'd0, rd_out}, {27'd0, e.rd});
                    chk({e.name, "_done_cycle"}, cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        op       = o;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        start    = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int t0;
        @(negedge clk);
        drive(v.op, v.a, v.b, v.rd);
        t0 = cyc;
        sb.push_back('{v.name, v.exp, v.rd, t0 + v.lat});
        #1 chk({v.name, "_busy_accept"}, {31'd0, busy}, 32'd1);
        for (int k = 1; k <= v.lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start    = 1'b0;
                rs1_data = $urandom;
                rs2_data = $urandom;
                rd_in    = 5'($urandom);
            end
            #1;
            if (k == v.lat - 1) chk({v.name, "_busy_last_run"}, {31'd0, busy}, 32'd1);
            if (k == v.lat)     chk({v.name, "_busy_done"}, {31'd0, busy}, 32'd0);
        end
        drain(v.name, 5);
    endtask

    initial begin
        int t0;
        fork
            monitor();
        join_none

        vecs.push_back('{"div_neg7_2",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd1,  32'hFFFFFFFD, 33});
        vecs.push_back('{"rem_neg7_2",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd2,  32'hFFFFFFFF, 33});
        vecs.push_back('{"divu_by0",      3'd5, 32'h12345678, 32'd0,        5'd3,  32'hFFFFFFFF, 1});
        vecs.push_back('{"remu_by0",      3'd7, 32'h12345678, 32'd0,        5'd4,  32'h12345678, 1});
        vecs.push_back('{"div_ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd5,  32'h80000000, 1});
        vecs.push_back('{"rem_ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h00000000, 1});
        vecs.push_back('{"mulh_min",      3'd1, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 1});
        vecs.push_back('{"mulhu_ones",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 1});
        vecs.push_back('{"mulhsu_ones",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'hFFFFFFFF, 1});
        vecs.push_back('{"mul_ones",      3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'h00000001, 1});
        vecs.push_back('{"mul_3x5",       3'd0, 32'd3,        32'd5,        5'd11, 32'd15,       1});
        vecs.push_back('{"mulh_neg1x1",   3'd1, 32'hFFFFFFFF, 32'd1,        5'd12, 32'hFFFFFFFF, 1});
        vecs.push_back('{"divu_100_7",    3'd5, 32'd100,      32'd7,        5'd13, 32'd14,       33});
        vecs.push_back('{"remu_100_7",    3'd7, 32'd100,      32'd7,        5'd14, 32'd2,        33});
        vecs.push_back('{"div_neg100_7",  3'd4, 32'hFFFFFF9C, 32'd7,        5'd15, 32'hFFFFFFF2, 33});
        vecs.push_back('{"rem_neg100_7",  3'd6, 32'hFFFFFF9C, 32'd7,        5'd16, 32'hFFFFFFFE, 33});
        vecs.push_back('{"div_100_neg7",  3'd4, 32'd100,      32'hFFFFFFF9, 5'd17, 32'hFFFFFFF2, 33});
        vecs.push_back('{"rem_100_neg7",  3'd6, 32'd100,      32'hFFFFFFF9, 5'd18, 32'd2,        33});
        vecs.push_back('{"divu_max_1",    3'd5, 32'hFFFFFFFF, 32'd1,        5'd19, 32'hFFFFFFFF, 33});
        vecs.push_back('{"divu_small",    3'd5, 32'd5,        32'h80000000, 5'd20, 32'd0,        33});
        vecs.push_back('{"remu_small",    3'd7, 32'd5,        32'h80000000, 5'd21, 32'd5,        33});
        vecs.push_back('{"div_min_1",     3'd4, 32'h80000000, 32'd1,        5'd22, 32'h80000000, 33});
        vecs.push_back('{"div_neg5_by0",  3'd4, 32'hFFFFFFFB, 32'd0,        5'd23, 32'hFFFFFFFF, 1});
        vecs.push_back('{"rem_neg5_by0",  3'd6, 32'hFFFFFFFB, 32'd0,        5'd24, 32'hFFFFFFFB, 1});

        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // kill mid-divide, then a fresh divide right after
        @(negedge clk);
        drive(3'd5, 32'd100, 32'd7, 5'd9);
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        #1;
        chk("kill_busy_c11", {31'd0, busy}, 32'd0);
        chk("kill_done_c11", {31'd0, done}, 32'd0);
        drive(3'd5, 32'd100, 32'd7, 5'd17);
        sb.push_back('{"after_kill", 32'd14, 5'd17, t0 + 44});
        #1 chk("after_kill_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        drain("after_kill", 40);

        // start together with kill in IDLE is not accepted
        @(negedge clk);
        drive(3'd4, 32'd50, 32'd5, 5'd25);
        kill = 1'b1;
        #1 chk("kill_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        #1 chk("kill_idle_busy_next", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        // kill in DONE still lets done pulse
        @(negedge clk);
        drive(3'd0, 32'd6, 32'd7, 5'd4);
        t0 = cyc;
        sb.push_back('{"kill_in_done", 32'd42, 5'd4, t0 + 1});
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        #1 chk("kill_in_done_busy", {31'd0, busy}, 32'd0);
        drain("kill_in_done", 5);

        // start during RUN and during DONE is ignored
        @(negedge clk);
        drive(3'd4, 32'hFFFFFFF9, 32'd2, 5'd3);
        t0 = cyc;
        sb.push_back('{"ignore_start", 32'hFFFFFFFD, 5'd3, t0 + 33});
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 5) @(negedge clk);
        drive(3'd5, 32'd100, 32'd7, 5'd30);
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 33) @(negedge clk);
        drive(3'd7, 32'd77, 32'd5, 5'd31);
        #1 chk("ignore_start_busy_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        drain("ignore_start", 5);
        repeat (40) @(negedge clk);

        // synchronous reset mid-divide
        @(negedge clk);
        drive(3'd4, 32'hFFFFFFF9, 32'd2, 5'd7);
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_busy",   {31'd0, busy}, 32'd0);
        chk("rst_mid_done",   {31'd0, done}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_rd_out", {27'd0, rd_out}, 32'd0);
        repeat (40) @(negedge clk);
        #1 chk("rst_mid_busy_late", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit, instantiated in the EX stage beside the ALU.
- Accepts one M-extension op and its operands, then produces a tagged result for writeback.
- Its busy output drives the hazard unit's muldiv_busy input, which stalls IF, ID and EX until the result is ready.
- Division uses a 32-iteration restoring algorithm. Multiply is single-shot or shift-add, selected by parameter.

Parameters:
MUL_FAST, 1, 1: multiply result is registered one cycle after accept. 0: 32-iteration shift-add, same latency as divide.
XLEN, 32, datapath width. Only 32 is supported.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only in IDLE
kill  in  1  pipeline flush; aborts any op in flight
op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_data  in  32  operand A (dividend / multiplicand)
rs2_data  in  32  operand B (divisor / multiplier)
rd_in  in  5  destination tag, carried to rd_out
busy  out  1  stall request to hazard unit
done  out  1  one-cycle result-valid pulse
result  out  32  result; valid only while done=1
rd_out  out  5  tag of the completing op

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, done=0, result=0, rd_out=0, busy=0. Reset asserted mid-operation returns to IDLE next edge with no done pulse.
- States: IDLE, RUN, DONE.
- Accept: start=1 && state==IDLE && !kill && !rst. On accept, capture op, rd_in and operands (abs values and sign flags for signed ops). start in RUN or DONE is ignored.
- busy (combinational) = !rst && ((state==IDLE && start && !kill) || state==RUN). busy is high in the accept cycle, so EX holds the instruction. busy is 0 in DONE, so the pipeline advances while result is presented.
- Timing, with accept at cycle 0:
  - Divide (normal case): RUN cycles 1..32; DONE at cycle 33 with done=1. busy is high cycles 0..32.
  - Multiply with MUL_FAST=1: IDLE->DONE directly; done at cycle 1; busy only in cycle 0.
  - Multiply with MUL_FAST=0: same timing as divide.
- DONE -> IDLE unconditionally next cycle. done is high exactly one cycle.
- Divide by zero (rs2==0): skips RUN; done at cycle 1.
  - DIV/DIVU -> 0xFFFFFFFF.
  - REM/REMU -> rs1.
- Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): skips RUN; done at cycle 1.
  - DIV -> 0x80000000.
  - REM -> 0.
- Divide arithmetic:
  - Unsigned restoring divide on magnitudes: 33-bit partial remainder, one quotient bit per cycle, MSB first.
  - Quotient is negated if operand signs differ (signed ops). Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Multiply arithmetic:
  - 64-bit product. Operands are extended per op: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
  - MUL returns product[31:0]; the others return product[63:32].
- kill:
  - In RUN: next state IDLE, no done, busy deasserts the next cycle.
  - In DONE: done still pulses; the pipeline is responsible for discarding it.
  - With start in IDLE: no accept.
- result and rd_out hold their last values outside DONE; consumers must qualify with done.

Decomposition:
- Shared package riscv_pkg:
  - muldiv_op_e enum (funct3 encoding above).
  - localparam DIV_ITERS=32.
  - muldiv_state_e {IDLE, RUN, DONE}.
- Sub-module div_iter: the serial unsigned divider datapath. It holds the remainder/quotient registers and 6-bit iteration counter and performs one restoring step per enable.
- muldiv_unit keeps the FSM, sign fixup, special-case detection and multiplier.

Test Plan:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> busy high cycles 0..32, done at cycle 33, result 0xFFFFFFFD. REM with same operands -> 0xFFFFFFFF.
- DIVU rs1=0x12345678, rs2=0 -> done at cycle 1, result 0xFFFFFFFF. REMU with same operands -> 0x12345678 at cycle 1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1. REM with same operands -> 0.
- MUL_FAST=1:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
  - MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
  - Each completes with done at cycle 1.
- DIVU 100/7 with kill at cycle 10 -> no done, busy=0 at cycle 11. A new DIVU 100/7 accepted at cycle 11 -> done at cycle 44, result 14, rd_out matches the new tag.
- Edge cases:
  - start with different operands during RUN and during DONE -> ignored; the original result and tag are returned.
  - rst asserted at cycle 5 of a DIV -> busy=0, done=0 from cycle 6, and no stale done later.
